// File: rtl/dma_pkg.sv
// ============================================================================
// Module : dma_pkg
// Brief  : Shared types and default widths for the DMA arbiter slice.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_pkg;

  localparam int DMA_ADD_LEN  = 16;
  localparam int DMA_DATA_LEN = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } dma_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotating-priority picker: first set request at or
//          above ptr, wrapping to the lowest set request otherwise.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] winner,
  output logic [ID_W-1:0]  winner_id
);

  logic w_found;

  // Pass one covers [ptr, N_REQ); pass two only fires when nothing there
  // requested, and the lowest set bit is then exactly the wrapped winner.
  always_comb begin
    w_found   = 1'b0;
    winner_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[i] && (ID_W'(i) >= ptr)) begin
        w_found   = 1'b1;
        winner_id = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[i]) begin
        w_found   = 1'b1;
        winner_id = ID_W'(i);
      end
    end
    winner = w_found ? (N_REQ'(1) << winner_id) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/dma_arbiter.sv
// ============================================================================
// Module : dma_arbiter
// Brief  : Shares one dma_controller among N_DEV requesters; holds the grant
//          until end_flag, then rotates priority.
//          Build option: DMA_ARB_FIXED_PRIO_EN (lowest index always wins).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_arbiter
  import dma_pkg::*;
#(
  parameter int N_DEV    = 4,
  parameter int ID_W     = 2,
  parameter int ADD_LEN  = DMA_ADD_LEN,
  parameter int DATA_LEN = DMA_DATA_LEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_DEV-1:0]           req_rqst,
  input  logic [N_DEV-1:0]           req_rd_wr,
  input  logic [N_DEV*ADD_LEN-1:0]   req_num_words,
  input  logic [N_DEV*(ADD_LEN+1)-1:0] req_start_addr,
  input  logic [N_DEV-1:0]           req_dev_ack,
  input  logic [N_DEV*DATA_LEN-1:0]  req_dev_in,
  output logic [N_DEV-1:0]           req_dma_ack,
  output logic [N_DEV-1:0]           req_end_flag,
  output logic [DATA_LEN-1:0]        req_dev_out,
  output logic [N_DEV-1:0]           grant,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy,
  output logic                       dma_rqst,
  output logic                       dma_rd_wr,
  output logic [ADD_LEN-1:0]         dma_num_words,
  output logic [ADD_LEN:0]           dma_start_addr,
  output logic                       dma_dev_ack,
  output logic [DATA_LEN-1:0]        dma_dev_in,
  input  logic                       dma_ack_in,
  input  logic [DATA_LEN-1:0]        dma_dev_out_in,
  input  logic                       dma_end_flag_in
);

  localparam logic [ID_W-1:0] c_last_id = ID_W'(N_DEV - 1);

  dma_arb_state_t    r_state, w_state_nxt;
  logic [N_DEV-1:0]  r_grant, w_win, r_end_flag;
  logic [ID_W-1:0]   r_grant_id, w_win_id, w_rr_ptr;
  logic              w_active;

  logic [ADD_LEN-1:0]  w_nw  [N_DEV];
  logic [ADD_LEN:0]    w_sa  [N_DEV];
  logic [DATA_LEN-1:0] w_din [N_DEV];

  for (genvar g = 0; g < N_DEV; g++) begin : g_slice
    assign w_nw[g]  = req_num_words[g*ADD_LEN +: ADD_LEN];
    assign w_sa[g]  = req_start_addr[g*(ADD_LEN+1) +: (ADD_LEN+1)];
    assign w_din[g] = req_dev_in[g*DATA_LEN +: DATA_LEN];
  end

  rr_pick #(.N_REQ(N_DEV), .ID_W(ID_W)) u_pick (
    .req       (req_rqst),
    .ptr       (w_rr_ptr),
    .winner    (w_win),
    .winner_id (w_win_id)
  );

`ifdef DMA_ARB_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [ID_W-1:0] r_rr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (r_state == RELEASE) begin
      r_rr_ptr <= (r_grant_id == c_last_id) ? '0 : r_grant_id + ID_W'(1);
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req_rqst) w_state_nxt = GRANT;
      GRANT:   w_state_nxt = dma_end_flag_in ? RELEASE : BUSY;
      BUSY:    if (dma_end_flag_in) w_state_nxt = RELEASE;
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_end_flag <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_end_flag <= '0;
      case (r_state)
        IDLE: begin
          if (|req_rqst) begin
            r_grant    <= w_win;
            r_grant_id <= w_win_id;
          end
        end
        GRANT, BUSY: begin
          if (dma_end_flag_in) r_end_flag <= r_grant;
        end
        RELEASE: begin
          r_grant    <= '0;
          r_grant_id <= '0;
        end
        default: ;
      endcase
    end
  end

  // Parameters follow the granted slice; the controller samples them late.
  assign w_active       = |r_grant;
  assign grant          = r_grant;
  assign grant_id       = r_grant_id;
  assign busy           = (r_state != IDLE);
  assign dma_rqst       = (r_state == GRANT);
  assign req_end_flag   = r_end_flag;
  assign dma_rd_wr      = w_active ? req_rd_wr[r_grant_id]   : 1'b0;
  assign dma_dev_ack    = w_active ? req_dev_ack[r_grant_id] : 1'b0;
  assign dma_num_words  = w_active ? w_nw[r_grant_id]        : '0;
  assign dma_start_addr = w_active ? w_sa[r_grant_id]        : '0;
  assign dma_dev_in     = w_active ? w_din[r_grant_id]       : '0;
  assign req_dma_ack    = r_grant & {N_DEV{dma_ack_in}};
  assign req_dev_out    = w_active ? dma_dev_out_in : '0;

endmodule

`default_nettype wire

// File: tb/tb_dma_arbiter.sv
// ============================================================================
// Module : tb_dma_arbiter
// Brief  : Self-checking bench for dma_arbiter (model + directed vectors).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_arbiter;

  localparam int N  = 4;
  localparam int AL = 16;
  localparam int DL = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_rqst, req_rd_wr, req_dev_ack;
  logic [N*AL-1:0] req_num_words;
  logic [N*(AL+1)-1:0] req_start_addr;
  logic [N*DL-1:0] req_dev_in;
  logic [N-1:0]    req_dma_ack, req_end_flag, grant;
  logic [DL-1:0]   req_dev_out, dma_dev_in, dma_dev_out_in;
  logic [1:0]      grant_id;
  logic            busy, dma_rqst, dma_rd_wr, dma_dev_ack;
  logic [AL-1:0]   dma_num_words;
  logic [AL:0]     dma_start_addr;
  logic            dma_ack_in, dma_end_flag_in;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_rqst = 0;
  int cnt_end1 = 0;
  bit dev2_ack_seen = 1'b0;

  dma_arbiter #(.N_DEV(N), .ID_W(2), .ADD_LEN(AL), .DATA_LEN(DL)) dut (
    .clk(clk), .reset(reset),
    .req_rqst(req_rqst), .req_rd_wr(req_rd_wr), .req_num_words(req_num_words),
    .req_start_addr(req_start_addr), .req_dev_ack(req_dev_ack), .req_dev_in(req_dev_in),
    .req_dma_ack(req_dma_ack), .req_end_flag(req_end_flag), .req_dev_out(req_dev_out),
    .grant(grant), .grant_id(grant_id), .busy(busy),
    .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr), .dma_num_words(dma_num_words),
    .dma_start_addr(dma_start_addr), .dma_dev_ack(dma_dev_ack), .dma_dev_in(dma_dev_in),
    .dma_ack_in(dma_ack_in), .dma_dev_out_in(dma_dev_out_in), .dma_end_flag_in(dma_end_flag_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the controller, how long since the grant, and whether
  // the completion has been seen (so this cycle is the hand-back cycle).
  int m_owner = -1;
  int m_ptr   = 0;
  int m_age   = 0;
  bit m_rel   = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner <= -1; m_ptr <= 0; m_age <= 0; m_rel <= 1'b0;
    end else if (m_rel) begin
`ifdef DMA_ARB_FIXED_PRIO_EN
      m_ptr <= 0;
`else
      m_ptr <= (m_owner + 1) % N;
`endif
      m_owner <= -1;
      m_rel   <= 1'b0;
    end else if (m_owner < 0) begin
      if (|req_rqst) begin
        m_owner <= pick(req_rqst, m_ptr);
        m_age   <= 0;
      end
    end else if (dma_end_flag_in) begin
      m_rel <= 1'b1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  logic [N-1:0] e_grant;
  bit           e_own;

  always @(negedge clk) begin
    e_own   = (m_owner >= 0);
    e_grant = e_own ? (N'(1) << m_owner) : '0;
    chk("grant",      32'(grant),        32'(e_grant));
    chk("grant_id",   32'(grant_id),     e_own ? 32'(m_owner) : 32'd0);
    chk("busy",       32'(busy),         32'(e_own));
    chk("dma_rqst",   32'(dma_rqst),     32'(e_own && m_age == 0 && !m_rel));
    chk("end_flag",   32'(req_end_flag), m_rel ? 32'(e_grant) : 32'd0);
    chk("rd_wr",      32'(dma_rd_wr),    e_own ? 32'(req_rd_wr[m_owner]) : 32'd0);
    chk("dev_ack",    32'(dma_dev_ack),  e_own ? 32'(req_dev_ack[m_owner]) : 32'd0);
    chk("num_words",  32'(dma_num_words),  e_own ? 32'(req_num_words[m_owner*AL +: AL]) : 32'd0);
    chk("start_addr", 32'(dma_start_addr), e_own ? 32'(req_start_addr[m_owner*(AL+1) +: (AL+1)]) : 32'd0);
    chk("dev_in",     32'(dma_dev_in),   e_own ? 32'(req_dev_in[m_owner*DL +: DL]) : 32'd0);
    chk("dma_ack",    32'(req_dma_ack),  32'(e_grant & {N{dma_ack_in}}));
    chk("dev_out",    32'(req_dev_out),  e_own ? 32'(dma_dev_out_in) : 32'd0);
    cnt_rqst += int'(dma_rqst);
    cnt_end1 += int'(req_end_flag[1]);
    if (req_dma_ack[2]) dev2_ack_seen = 1'b1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick();
  endtask

  // Plays the controller: waits for rqst, returns nack acks, then end_flag.
  task automatic serve(input int nack, input bit zero, output int id);
    int waited = 0;
    while (!dma_rqst && waited < 20) begin
      tick();
      waited++;
    end
    if (!dma_rqst) begin
      chk("rqst_timeout", 32'(dma_rqst), 32'd1);
      id = -1;
      return;
    end
    id = int'(grant_id);
    if (!zero) begin
      tick();
      repeat (nack) begin
        dma_ack_in     = 1'b1;
        dma_dev_out_in = DL'($urandom);
        tick();
        dma_ack_in     = 1'b0;
        tick();
      end
    end
    dma_end_flag_in = 1'b1;
    tick();
    dma_end_flag_in = 1'b0;
  endtask

  task automatic set_dev(input int d, input bit rw, input int nw, input int sa, input int din);
    req_rd_wr[d] = rw;
    req_num_words[d*AL +: AL] = AL'(nw);
    req_start_addr[d*(AL+1) +: (AL+1)] = (AL+1)'(sa);
    req_dev_in[d*DL +: DL] = DL'(din);
  endtask

  int id, c0, e0;
  int exp_order [4];

  initial begin
    reset = 1'b0; req_rqst = '0; req_rd_wr = '0; req_dev_ack = '0;
    req_num_words = '0; req_start_addr = '0; req_dev_in = '0;
    dma_ack_in = 1'b0; dma_dev_out_in = '0; dma_end_flag_in = 1'b0;
    tick(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_rqst",  32'(dma_rqst), 32'd0);
    chk("rst_end",   32'(req_end_flag), 32'd0);
    reset = 1'b1;
    tick();

    // Spurious completion while idle must be ignored
    dma_end_flag_in = 1'b1;
    tick();
    dma_end_flag_in = 1'b0;
    chk("spur_busy", 32'(busy), 32'd0);
    tick();
    chk("spur_end", 32'(req_end_flag), 32'd0);

    // Dev1 read, 4 words at 0x0200; drops its request after the grant
    set_dev(1, 1'b1, 4, 'h200, 0);
    req_dev_ack[1] = 1'b1;
    c0 = cnt_rqst; e0 = cnt_end1;
    req_rqst = 4'b0010;
    tick();
    chk("t1_grant", 32'(grant), 32'h2);
    chk("t1_rqst",  32'(dma_rqst), 32'd1);
    req_rqst = '0;
    serve(4, 1'b0, id);
    chk("t1_id",   32'(id), 32'd1);
    chk("t1_sa",   32'(dma_start_addr), 32'h200);
    chk("t1_nw",   32'(dma_num_words), 32'd4);
    tick();
    chk("t1_rqst_pulses", 32'(cnt_rqst - c0), 32'd1);
    chk("t1_end_pulses",  32'(cnt_end1 - e0), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);

    // Dev0 and dev2 both keep requesting from rr_ptr=0
    do_reset();
    set_dev(0, 1'b1, 2, 'h100, 0);
    set_dev(2, 1'b1, 3, 'h180, 0);
`ifdef DMA_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 2, 0, 2};
`endif
    req_rqst = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      serve(1, 1'b0, id);
      chk($sformatf("t2_order%0d", k), 32'(id), 32'(exp_order[k]));
    end
    req_rqst = '0;
    tick(2);

    // Dev3 write while idle dev2 wiggles ack and drives 0xDEAD
    do_reset();
    set_dev(3, 1'b0, 2, 'h300, 'h1234);
    set_dev(2, 1'b0, 0, 0, 'hDEAD);
    req_dev_ack[3] = 1'b1;
    dev2_ack_seen = 1'b0;
    req_rqst = 4'b1000;
    tick();
    chk("t3_grant", 32'(grant), 32'h8);
    chk("t3_dev_in", 32'(dma_dev_in), 32'h1234);
    fork
      begin
        repeat (12) begin
          req_dev_ack[2] = ~req_dev_ack[2];
          tick();
        end
      end
      begin
        serve(2, 1'b0, id);
        req_rqst = '0;
      end
    join
    chk("t3_id", 32'(id), 32'd3);
    chk("t3_dev2_ack", 32'(dev2_ack_seen), 32'd0);

    // Zero-word request from dev1: completion in the grant cycle
    do_reset();
    set_dev(1, 1'b1, 0, 'h240, 0);
    req_rqst = 4'b0010;
    serve(0, 1'b1, id);
    chk("t4_end_flag", 32'(req_end_flag), 32'h2);
    req_rqst = '0;
    tick();
    chk("t4_idle", 32'(busy), 32'd0);

    // Async reset in BUSY, then re-arbitrate from pointer 0
    do_reset();
    set_dev(0, 1'b1, 1, 'h100, 0);
    req_rqst = 4'b0001;
    serve(1, 1'b0, id);
    req_rqst = '0;
    tick();
    req_rqst = 4'b0010;
    tick(2);
    chk("t5_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_grant_rst", 32'(grant), 32'd0);
    chk("t5_rqst_rst",  32'(dma_rqst), 32'd0);
    chk("t5_busy_rst",  32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    req_rqst = 4'b0101;
    tick();
    chk("t5_regrant", 32'(grant), 32'h1);
    serve(1, 1'b0, id);
    req_rqst = '0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_arbiter.md
Name: dma_arbiter

Overview:
Shares the single dma_controller instance between N_DEV peripheral requesters. Picks one requester, presents its transfer parameters and device-side handshake to the controller, and routes the controller's dma_ack, data and end_flag back to the granted device only. Holds the grant until the controller signals completion, then rotates priority. Sits between the peripherals and dma_controller; the OpenMSP430 side of dma_controller is untouched.

Parameters:
N_DEV, 4, number of requesters (2..8)
ID_W, 2, width of grant index; must satisfy 2^ID_W >= N_DEV
ADD_LEN, 16, address/word-count width, matches dma_controller
DATA_LEN, 16, data width, matches dma_controller

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_rqst  in  N_DEV  per-device transfer request, level
req_rd_wr  in  N_DEV  per-device direction, 1=read memory->device
req_num_words  in  N_DEV*ADD_LEN  per-device word count; slice i = [i*ADD_LEN +: ADD_LEN]
req_start_addr  in  N_DEV*(ADD_LEN+1)  per-device byte start address
req_dev_ack  in  N_DEV  per-device ready/ack toward DMA
req_dev_in  in  N_DEV*DATA_LEN  per-device write data
req_dma_ack  out  N_DEV  dma_ack routed to granted device
req_end_flag  out  N_DEV  one-cycle completion pulse to granted device
req_dev_out  out  DATA_LEN  read data, broadcast; valid only with req_dma_ack[i]
grant  out  N_DEV  one-hot current grant, registered
grant_id  out  ID_W  index of current grant
busy  out  1  high from GRANT through RELEASE
dma_rqst  out  1  to controller rqst
dma_rd_wr  out  1  to controller rd_wr
dma_num_words  out  ADD_LEN  to controller num_words
dma_start_addr  out  ADD_LEN+1  to controller start_addr
dma_dev_ack  out  1  to controller dev_ack
dma_dev_in  out  DATA_LEN  to controller dev_in
dma_ack_in  in  1  from controller dma_ack
dma_dev_out_in  in  DATA_LEN  from controller dev_out
dma_end_flag_in  in  1  from controller end_flag

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, grant_id=0, rr_ptr=0, dma_rqst=0, busy=0, req_end_flag=0. Every combinational output is 0 while grant=0.
- States: IDLE, GRANT, BUSY, RELEASE.
- IDLE: if |req_rqst, winner = first set bit scanning from rr_ptr upward with wrap. Register grant/grant_id; go to GRANT. Arbitration latency is 1 cycle from request to grant.
- GRANT (1 cycle): dma_rqst=1, busy=1; go to BUSY.
- BUSY: dma_rqst=0. Stay until dma_end_flag_in=1, then go to RELEASE.
- RELEASE (1 cycle): req_end_flag[grant_id]=1 (registered pulse). rr_ptr = grant_id+1, wrapping to 0 at N_DEV. Clear grant; go to IDLE. A request that remains asserted is re-arbitrated in IDLE on the next cycle.
- dma_end_flag_in is accepted in GRANT or BUSY; a zero-word request ends within 2 cycles of GRANT.
- Muxing while grant!=0 (GRANT/BUSY/RELEASE): dma_rd_wr, dma_num_words, dma_start_addr, dma_dev_ack and dma_dev_in come from slice grant_id. These are held stable for the whole grant because the controller latches them one cycle after rqst.
- Return path: req_dma_ack = grant & {N_DEV{dma_ack_in}}. req_dev_out = dma_dev_out_in, or 0 when no grant.
- Ungranted devices never see dma_ack or end_flag. Their req_dev_ack and data are ignored.
- If the granted device drops req_rqst mid-transfer, it is ignored and the grant is held until end_flag.
- If dma_end_flag_in arrives in IDLE (spurious), it is ignored.

Optional Feature:
DMA_ARB_FIXED_PRIO_EN:
- Defined: rr_ptr is tied to 0; the lowest-index requesting device always wins.
- Undefined: round-robin as above.
- Macro state does not change the port list.

Decomposition:
- Package dma_pkg: state encoding localparams (IDLE=0, GRANT=1, BUSY=2, RELEASE=3), default ADD_LEN/DATA_LEN.
- Sub-module rr_pick (combinational): inputs req vector and ptr; outputs one-hot winner and index. Reusable by other shared-resource arbiters.

Test Plan:
- Dev1 only, read, num_words=4, start_addr=0x0200 -> grant=0010 one cycle after rqst. dma_start_addr=0x0200 and dma_num_words=4 are stable until end. dma_rqst pulses once. req_end_flag[1] pulses once.
- Dev0 and dev2 request simultaneously, rr_ptr=0 -> dev0 served first, then dev2. With dev0 re-requesting, the next grant goes to dev2, then dev0 (alternation).
- Same stimulus with DMA_ARB_FIXED_PRIO_EN -> dev0 granted every time while it keeps requesting; dev2 waits.
- Write from dev3 with dev2 toggling req_dev_ack and data 0xDEAD -> dma_dev_in carries only dev3 data. req_dma_ack[2] stays 0 throughout.
- num_words=0 from dev1 -> end_flag returns; req_end_flag[1] pulses within 3 cycles of grant; FSM returns to IDLE.
- reset=0 asserted in BUSY -> grant=0, dma_rqst=0 and busy=0 immediately (async). After release, the next request is arbitrated from rr_ptr=0.
